seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Parametrised, time-multiplexed hex display driver for common-anode/cathode multi-digit seven-segment panels. Takes a packed NUM_DIGITS-nibble value plus per-digit decimal points. Double-buffers it on a load strobe and scans one digit per refresh slot. Drives shared segment lines and per-digit enables. Sits between the design's result registers and the board's seven-segment pins, replacing per-digit single-nibble decoders.

## Interface
- NUM_DIGITS, 4, digit count, legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot, minimum 2.
- SEG_ACTIVE_LOW, 1, 1 drives segment/dp outputs inverted (lit = 0).
- AN_ACTIVE_LOW, 1, 1 drives digit enables inverted (selected = 0).
- LZ_BLANK, 1, 1 enables leading-zero blanking.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- value_in  in  4*NUM_DIGITS  packed hex digits; digit i = value_in[4i+3:4i]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  capture value_in/dp_in into pending buffer on this edge.
- enable  in  1  0 = panel dark; scanning continues.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
- dp_out  out  1  decimal point of selected digit.
- an_out  out  NUM_DIGITS  one-hot digit enable; bit i selects digit i.
- frame_done  out  1  one-cycle pulse after each full scan.

## Operation
- Registers:
  - Refresh counter: 0..REFRESH_DIV-1.
  - Digit index: 0..NUM_DIGITS-1.
  - Pending buffer: value and dp.
  - Display buffer: value and dp.
- load=1 writes value_in/dp_in into the pending buffer. The display buffer copies pending only at a frame boundary, i.e. the edge where the digit index wraps NUM_DIGITS-1 -> 0. This prevents tearing.
- Scan order is 0,1,...,NUM_DIGITS-1,0,... With NUM_DIGITS=1 the index stays 0 and the boundary occurs every REFRESH_DIV cycles.
- Decode, active-high pattern before polarity:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Leading-zero blanking (LZ_BLANK=1): digit i is blanked (pattern 00) when it and every more-significant digit of the display buffer are 0. Digit 0 is never blanked, so value 0 shows "0".
- dp_out follows the display-buffer dp of the selected digit, regardless of blanking.
- enable=0: all an_out inactive, seg_out and dp_out inactive. Counter, index, buffers and frame_done continue normally.
- Polarity: SEG_ACTIVE_LOW inverts seg_out and dp_out; AN_ACTIVE_LOW inverts an_out.

## Timing
- Reset values:
  - Counter 0, index 0, both buffers 0.
  - an_out all inactive, seg_out and dp_out inactive, frame_done 0.
- Counter increments every cycle. At count REFRESH_DIV-1 it returns to 0 and the index advances on the same edge.
- seg_out, dp_out and an_out are registered. They reflect the index, display buffer and enable one cycle after those change.
  - First edge after reset release: digit 0 is selected showing "0".
- Each digit is selected for exactly REFRESH_DIV cycles. There is no overlap: at most one an_out bit is active in any cycle.
- frame_done is high for exactly the one cycle following a wrap edge. It coincides with the first cycle digit 0 shows the new display buffer.
- Load latency to panel: the new value appears at the next wrap edge + 1 cycle, i.e. up to NUM_DIGITS*REFRESH_DIV+1 cycles.
- Load on the wrap edge itself:
  - The display buffer takes the old pending contents.
  - The new value is shown from the following frame.
- Multiple loads within one frame: the last one wins.
- Asynchronous rst mid-frame immediately forces all reset values. Pending loads are discarded.

## Test plan
- Reset: assert rst mid-scan -> an_out=4'b1111, seg_out=7'h7F, dp_out=1, frame_done=0 immediately (active-low defaults). After release, an_out=4'b1110, seg_out=~7'h3F.
- Scan (NUM_DIGITS=4, REFRESH_DIV=4): an_out steps 1110,1101,1011,0111, each held 4 cycles. frame_done pulses every 16 cycles, in the first cycle of 1110.
- Decode: load each of 0x0..0xF into digit 0 with LZ_BLANK=0 -> seg_out matches the listed table (inverted), e.g. A -> ~7'h77.
- Blanking and dp: load value 0x0050, dp_in=4'b0100:
  - Digit 3 shows seg 7F (blank).
  - Digit 2 shows seg 7F (blank) with dp_out=0.
  - Digit 1 shows ~6D; digit 0 shows ~3F.
- Double buffer: display 0x1234, load 0xABCD during digit 1, then load 0x5678 on the wrap edge:
  - Remainder of the frame still shows 1234.
  - Next frame shows ABCD.
  - Following frame shows 5678.
- Enable: drop enable for 10 cycles mid-slot -> an_out=1111, seg_out=7F. Index timing is unchanged on re-enable: frame_done period stays 16.

Source files
------------

// File: rtl/seg_display_if.sv
// seg_display_if: display data, control and panel pins of the seven-segment scanner
interface seg_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    enable;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;
  modport master (
    output value_in, dp_in, load, enable,
    input  seg_out, dp_out, an_out, frame_done
  );
  modport slave (
    input  value_in, dp_in, load, enable,
    output seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: double-buffered, time-multiplexed hex driver for multi-digit seven-segment panels
module seg_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [6:0] DECODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  wrap_q, wrap_d;
  logic                  frame_q, frame_d;
  logic                  last_slot, wrap, blank;
  logic [3:0]            nib;
  logic [6:0]            pat;
  logic [NUM_DIGITS-1:0] one_hot;
  // Slot timing, buffer transfer at frame wrap, and the next panel drive from the current digit
  always_comb begin
    last_slot  = cnt_q == CW'(REFRESH_DIV - 1);
    wrap       = last_slot && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d      = last_slot ? '0 : cnt_q + CW'(1);
    idx_d      = last_slot ? (wrap ? '0 : idx_q + IW'(1)) : idx_q;
    pend_val_d = bus.load ? bus.value_in : pend_val_q;
    pend_dp_d  = bus.load ? bus.dp_in : pend_dp_q;
    disp_val_d = wrap ? pend_val_q : disp_val_q;
    disp_dp_d  = wrap ? pend_dp_q : disp_dp_q;
    nib        = disp_val_q[{idx_q, 2'b00} +: 4];
    blank      = LZ_BLANK && idx_q != '0 && (disp_val_q >> {idx_q, 2'b00}) == '0;
    pat        = bus.enable && !blank ? DECODE[nib] : 7'h00;
    one_hot    = '0;
    one_hot[idx_q] = bus.enable;
    seg_d      = pat ^ {7{SEG_ACTIVE_LOW}};
    dp_d       = (bus.enable & disp_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    an_d       = one_hot ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    wrap_d     = wrap;
    frame_d    = wrap_q;
  end
  // State and registered panel outputs; reset blanks the panel immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      wrap_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      wrap_q     <= wrap_d;
      frame_q    <= frame_d;
    end
  end
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: randomized and directed checks of the scanner against a cycle-count reference model
module tb_seg_display_mux;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   k = 0;
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [3:0]  m_pdp = '0, m_ddp = '0;
  always #5 clk = ~clk;
  seg_display_if #(.NUM_DIGITS(N)) bus ();
  seg_display_mux #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask
  // One clock edge: the model predicts panel state from the buffers before the edge, then applies the edge
  task automatic step();
    int slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd, blank, en, ld;
    @(posedge clk);
    en = bus.enable;
    ld = bus.load;
    k++;
    slot  = ((k - 1) / DIV) % N;
    blank = slot > 0 && (m_disp >> (4 * slot)) == 16'h0;
    e_an  = en ? ~(4'b0001 << slot) : 4'hF;
    e_seg = en ? ~(blank ? 7'h00 : SEG_TAB[m_disp[4*slot +: 4]]) : 7'h7F;
    e_dp  = en ? ~m_ddp[slot] : 1'b1;
    e_fd  = k > 1 && (k - 1) % FR == 0;
    if (k % FR == 0) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
    end
    if (ld) begin
      m_pend = bus.value_in;
      m_pdp  = bus.dp_in;
    end
    #1;
    chk("an_out", bus.an_out, e_an);
    chk("seg_out", bus.seg_out, e_seg);
    chk("dp_out", bus.dp_out, e_dp);
    chk("frame_done", bus.frame_done, e_fd);
  endtask
  task automatic load_step(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask
  task automatic run_to(input int ph);
    while (k % FR != ph) step();
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_an", bus.an_out, 4'hF);
    chk("rst_seg", bus.seg_out, 7'h7F);
    chk("rst_dp", bus.dp_out, 1'b1);
    chk("rst_fd", bus.frame_done, 1'b0);
    bus.load = 1'b0;
    k = 0;
    m_pend = '0;
    m_disp = '0;
    m_pdp  = '0;
    m_ddp  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_an", bus.an_out, 4'b1110);
    chk("post_rst_seg", bus.seg_out, 7'h40);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.enable   = 1'b1;
    async_reset();
    repeat (2 * FR) step();
    for (int d = 0; d < 16; d++) begin
      load_step(16'(d), 4'b0000);
      repeat (FR + 2) step();
    end
    load_step(16'h0050, 4'b0100);
    repeat (2 * FR) step();
    load_step(16'h1234, 4'b0000);
    run_to(0);
    run_to(DIV + 1);
    load_step(16'hABCD, 4'b0010);
    run_to(FR - 1);
    load_step(16'h5678, 4'b1000);
    repeat (3 * FR) step();
    run_to(DIV + 2);
    bus.enable = 1'b0;
    repeat (10) step();
    bus.enable = 1'b1;
    repeat (2 * FR) step();
    repeat (600) begin
      bus.value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      bus.dp_in    = 4'($urandom);
      bus.load     = $urandom_range(0, 7) == 0;
      bus.enable   = $urandom_range(0, 15) != 0;
      step();
    end
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    load_step(16'h9999, 4'b1111);
    run_to(5);
    async_reset();
    repeat (2 * FR) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
